// File: rtl/image_window_ctrl_if.sv
// Pixel stream in / 3x3 window stream out, seen from the window controller.
// slave: the controller; master: the upstream source and downstream kernel.
interface image_window_ctrl_if;
    logic [7:0]  i_pixel_data;
    logic        i_pixel_data_valid;
    logic        o_ready;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;
    logic        o_intr;

    modport slave (
        input  i_pixel_data, i_pixel_data_valid,
        output o_ready, o_pixel_data, o_pixel_data_valid, o_intr
    );

    modport master (
        output i_pixel_data, i_pixel_data_valid,
        input  o_ready, o_pixel_data, o_pixel_data_valid, o_intr
    );
endinterface

// File: rtl/image_window_ctrl.sv
// Four rotating line buffers feeding a 3x3 window generator for the convolution kernels.
// One o_intr pulse per completed output line asks upstream for the next line.
module image_window_ctrl #(
    parameter int unsigned IMG_WIDTH = 512
) (
    input logic               i_clk,
    input logic               i_rstn,
    image_window_ctrl_if.slave io_bus
);
    localparam int unsigned PW = $clog2(IMG_WIDTH);
    localparam int unsigned CW = $clog2(4 * IMG_WIDTH + 1);
    localparam logic [CW-1:0] LINE    = CW'(IMG_WIDTH);
    localparam logic [CW-1:0] TRIG    = CW'(3 * IMG_WIDTH);
    localparam logic [CW-1:0] FULL    = CW'(4 * IMG_WIDTH);
    localparam logic [PW-1:0] LAST_WR = PW'(IMG_WIDTH - 1);
    localparam logic [PW-1:0] LAST_RD = PW'(IMG_WIDTH - 3);

    typedef enum logic {
        S_IDLE,
        S_READ
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_line [4][IMG_WIDTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [1:0]    r_wr_buf;
    logic [1:0]    r_rd_base;
    logic [CW-1:0] r_fill_cnt;
    logic [71:0]   r_pixel_data;
    logic          r_pixel_data_valid;
    logic          r_intr;
    logic          w_ready;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_release;
    logic [71:0]   w_window;

    assign w_ready = (r_fill_cnt < FULL);
    assign w_wr_en = io_bus.i_pixel_data_valid && w_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_fill_cnt >= TRIG) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_rd_en = 1'b1;
                if (r_rd_ptr == LAST_RD) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Line storage carries no reset; the fill counter alone defines which contents are live.
    always_ff @(posedge i_clk) begin
        if (i_rstn && w_wr_en) begin
            r_line[r_wr_buf][r_wr_ptr] <= io_bus.i_pixel_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_wr_ptr   <= '0;
            r_wr_buf   <= '0;
            r_rd_ptr   <= '0;
            r_rd_base  <= '0;
            r_fill_cnt <= '0;
        end else begin
            if (w_wr_en) begin
                if (r_wr_ptr == LAST_WR) begin
                    r_wr_ptr <= '0;
                    r_wr_buf <= r_wr_buf + 2'd1;
                end else begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
            end
            if (w_release) begin
                r_rd_ptr  <= '0;
                r_rd_base <= r_rd_base + 2'd1;
            end else if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_fill_cnt <= r_fill_cnt + CW'(w_wr_en) - (w_release ? LINE : '0);
        end
    end

    // Row 0 is the oldest buffer (rd_base); byte 3*r+c holds row r, column c.
    always_comb begin
        w_window = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                w_window[8*(3*r+c) +: 8] = r_line[r_rd_base + 2'(r)][r_rd_ptr + PW'(c)];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_pixel_data       <= '0;
            r_pixel_data_valid <= 1'b0;
            r_intr             <= 1'b0;
        end else begin
            r_pixel_data_valid <= w_rd_en;
            r_intr             <= w_release;
            if (w_rd_en) begin
                r_pixel_data <= w_window;
            end
        end
    end

    assign io_bus.o_ready            = w_ready;
    assign io_bus.o_pixel_data       = r_pixel_data;
    assign io_bus.o_pixel_data_valid = r_pixel_data_valid;
    assign io_bus.o_intr             = r_intr;
endmodule

// File: tb/tb_image_window_ctrl.sv
// Bench for image_window_ctrl at IMG_WIDTH=8: directed window/latency scenarios plus a
// scoreboard that rebuilds every window from the accepted pixel history.
module tb_image_window_ctrl;
    localparam int W = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    image_window_ctrl_if bus();

    image_window_ctrl #(.IMG_WIDTH(W)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .io_bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: every accepted pixel in arrival order; output line k uses input lines k..k+2.
    logic [7:0]  px_q[$];
    int          released = 0;
    int          out_line = 0;
    int          out_col  = 0;
    logic [71:0] last_win = '0;
    int          n_valid  = 0;
    int          n_intr   = 0;
    logic        p_rstn   = 1'b0;
    logic        p_acc    = 1'b0;
    logic [7:0]  p_data   = '0;

    function automatic logic [71:0] model_window(input int line, input int col);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[8*(3*r+c) +: 8] = px_q[(line + r) * W + col + c];
        return w;
    endfunction

    always @(negedge clk) begin
        #1;
        p_rstn = rstn;
        p_acc  = bus.i_pixel_data_valid && bus.o_ready;
        p_data = bus.i_pixel_data;
    end

    always @(posedge clk) begin
        logic [71:0] exp_w;
        logic        exp_intr;
        logic        exp_ready;
        #1;
        if (!p_rstn) begin
            px_q.delete();
            released = 0; out_line = 0; out_col = 0; last_win = '0;
            n_valid = 0; n_intr = 0;
            n_checks++;
            if (bus.o_pixel_data_valid !== 1'b0 || bus.o_intr !== 1'b0 ||
                bus.o_pixel_data !== 72'h0 || bus.o_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_outputs: got v=%b i=%b r=%b d=%h expected v=0 i=0 r=1 d=0",
                         bus.o_pixel_data_valid, bus.o_intr, bus.o_ready, bus.o_pixel_data);
            end
        end else begin
            if (p_acc) px_q.push_back(p_data);
            if (bus.o_pixel_data_valid === 1'b1) begin
                n_valid++;
                n_checks++;
                if (px_q.size() < (out_line + 3) * W) begin
                    n_fail++;
                    $display("FAIL early_valid: got valid with %0d pixels stored, expected at least %0d",
                             px_q.size(), (out_line + 3) * W);
                    exp_w = 'x;
                end else begin
                    exp_w = model_window(out_line, out_col);
                    if (bus.o_pixel_data !== exp_w) begin
                        n_fail++;
                        $display("FAIL window line %0d col %0d: got %h expected %h",
                                 out_line, out_col, bus.o_pixel_data, exp_w);
                    end
                end
                exp_intr = (out_col == W - 3);
                n_checks++;
                if (bus.o_intr !== exp_intr) begin
                    n_fail++;
                    $display("FAIL intr_on_valid: got %b expected %b", bus.o_intr, exp_intr);
                end
                last_win = exp_w;
                if (exp_intr) begin
                    out_line++; out_col = 0; released++;
                end else begin
                    out_col++;
                end
            end else begin
                n_checks++;
                if (bus.o_intr !== 1'b0 || bus.o_pixel_data !== last_win) begin
                    n_fail++;
                    $display("FAIL idle_hold: got intr=%b d=%h expected intr=0 d=%h",
                             bus.o_intr, bus.o_pixel_data, last_win);
                end
            end
            if (bus.o_intr === 1'b1) n_intr++;
            exp_ready = ((px_q.size() - released * W) < 4 * W);
            n_checks++;
            if (bus.o_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL ready: got %b expected %b", bus.o_ready, exp_ready);
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] d);
        @(negedge clk);
        bus.i_pixel_data_valid = v;
        bus.i_pixel_data       = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        bus.i_pixel_data_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn = 1'b0;
        bus.i_pixel_data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.o_pixel_data_valid !== 1'b0 || bus.o_intr !== 1'b0 ||
            bus.o_ready !== 1'b1 || bus.o_pixel_data !== 72'h0) begin
            n_fail++;
            $display("FAIL test_reset: got v=%b i=%b r=%b d=%h expected v=0 i=0 r=1 d=0",
                     bus.o_pixel_data_valid, bus.o_intr, bus.o_ready, bus.o_pixel_data);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Writes land on edges 0..23; the first window is visible two edges after the last one.
    task automatic test_first_window(input string tag);
        int first = -1, nv = 0, last_t = -1, icnt = 0, it = -1;
        logic [71:0] fw = '0, lw = '0;
        for (int t = 0; t < 40; t++) begin
            if (t < 24) drive(1'b1, 8'((t / 8) * 16 + t % 8));
            else        drive(1'b0, 8'h00);
            @(posedge clk);
            #1;
            if (bus.o_pixel_data_valid === 1'b1) begin
                if (first < 0) begin first = t; fw = bus.o_pixel_data; end
                nv++; last_t = t; lw = bus.o_pixel_data;
            end
            if (bus.o_intr === 1'b1) begin icnt++; it = t; end
        end
        n_checks++;
        if (first != 25) begin n_fail++; $display("FAIL %s first_valid_cycle: got %0d expected 25", tag, first); end
        n_checks++;
        if (fw !== 72'h22_21_20_12_11_10_02_01_00) begin
            n_fail++; $display("FAIL %s first_window: got %h expected 222120121110020100", tag, fw);
        end
        n_checks++;
        if (nv != 6) begin n_fail++; $display("FAIL %s valid_count: got %0d expected 6", tag, nv); end
        n_checks++;
        if (last_t != first + 5) begin n_fail++; $display("FAIL %s contiguous: got last %0d expected %0d", tag, last_t, first + 5); end
        n_checks++;
        if (lw !== 72'h27_26_25_17_16_15_07_06_05) begin
            n_fail++; $display("FAIL %s last_window: got %h expected 272625171615070605", tag, lw);
        end
        n_checks++;
        if (icnt != 1 || it != last_t) begin
            n_fail++; $display("FAIL %s intr_pulse: got count %0d at %0d expected 1 at %0d", tag, icnt, it, last_t);
        end
    endtask

    task automatic test_next_line();
        logic [71:0] w = '0;
        bit seen = 0;
        for (int c = 0; c < W; c++) drive(1'b1, 8'(8'h30 + c));
        drive(1'b0, 8'h00);
        for (int t = 0; t < 30 && !seen; t++) begin
            @(posedge clk);
            #1;
            if (bus.o_pixel_data_valid === 1'b1) begin seen = 1; w = bus.o_pixel_data; end
        end
        n_checks++;
        if (!seen || w !== 72'h32_31_30_22_21_20_12_11_10) begin
            n_fail++; $display("FAIL next_line_window: got seen=%0d %h expected 323130222120121110", seen, w);
        end
        repeat (10) drive(1'b0, 8'h00);
    endtask

    task automatic test_back_pressure();
        int acc = 0;
        do_reset();
        for (int t = 0; t < 40; t++) begin
            drive(1'b1, 8'($urandom));
            if (bus.o_ready === 1'b1) acc++;
        end
        repeat (40) drive(1'b0, 8'h00);
        n_checks++;
        if (n_intr != acc / W - 2) begin n_fail++; $display("FAIL bp_lines: got %0d expected %0d", n_intr, acc / W - 2); end
        n_checks++;
        if (n_valid != 6 * n_intr) begin n_fail++; $display("FAIL bp_valids: got %0d expected %0d", n_valid, 6 * n_intr); end
    endtask

    task automatic test_write_during_release();
        int acc = 0, aligned = 0;
        bit wrote;
        do_reset();
        for (int t = 0; t < 300 && acc < 12 * W; t++) begin
            drive(1'b1, 8'($urandom));
            wrote = (bus.o_ready === 1'b1);
            if (wrote) acc++;
            @(posedge clk);
            #1;
            if (wrote && bus.o_intr === 1'b1) aligned++;
        end
        repeat (40) drive(1'b0, 8'h00);
        n_checks++;
        if (acc != 12 * W) begin n_fail++; $display("FAIL wdr_accepted: got %0d expected %0d", acc, 12 * W); end
        n_checks++;
        if (aligned == 0) begin n_fail++; $display("FAIL wdr_aligned: got 0 expected >0"); end
        n_checks++;
        if (n_intr != 10) begin n_fail++; $display("FAIL wdr_lines: got %0d expected 10", n_intr); end
        n_checks++;
        if (n_valid != 60) begin n_fail++; $display("FAIL wdr_valids: got %0d expected 60", n_valid); end
    endtask

    task automatic test_random_gaps();
        int acc = 0, exp_lines;
        do_reset();
        for (int t = 0; t < 200; t++) begin
            drive($urandom_range(0, 99) < 60, 8'($urandom));
            if (bus.i_pixel_data_valid && bus.o_ready === 1'b1) acc++;
        end
        repeat (40) drive(1'b0, 8'h00);
        exp_lines = (acc >= 3 * W) ? acc / W - 2 : 0;
        n_checks++;
        if (n_intr != exp_lines) begin n_fail++; $display("FAIL gaps_lines: got %0d expected %0d", n_intr, exp_lines); end
        n_checks++;
        if (n_valid != 6 * exp_lines) begin n_fail++; $display("FAIL gaps_valids: got %0d expected %0d", n_valid, 6 * exp_lines); end
    endtask

    task automatic test_midline_reset();
        int nv = 0;
        do_reset();
        for (int t = 0; t < 24; t++) drive(1'b1, 8'($urandom));
        drive(1'b0, 8'h00);
        for (int t = 0; t < 30 && nv < 3; t++) begin
            @(posedge clk);
            #1;
            if (bus.o_pixel_data_valid === 1'b1) nv++;
        end
        n_checks++;
        if (nv != 3) begin n_fail++; $display("FAIL mid_reach_col3: got %0d valids expected 3", nv); end
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.o_pixel_data_valid !== 1'b0 || bus.o_pixel_data !== 72'h0) begin
            n_fail++; $display("FAIL mid_reset_drop: got v=%b d=%h expected v=0 d=0", bus.o_pixel_data_valid, bus.o_pixel_data);
        end
        @(negedge clk);
        rstn = 1'b1;
        test_first_window("after_reset");
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        bus.i_pixel_data_valid = 1'b0;
        bus.i_pixel_data       = 8'h00;
        test_reset();
        test_first_window("first");
        test_next_line();
        test_back_pressure();
        test_write_during_release();
        test_random_gaps();
        test_midline_reset();
        repeat (2) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
